// File: rtl/vending_return_controller.sv
// Change-return sequencer: inactivity timer, return decision, and
// largest-coin-first hopper drive under a ready handshake.
module vending_return_controller #(
  parameter int TOTAL_BITS  = 31,
  parameter int NUM_COINS   = 3,
  parameter int WAIT_CYCLES = 100,
  parameter int COIN_VAL0   = 100,
  parameter int COIN_VAL1   = 500,
  parameter int COIN_VAL2   = 1000
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [TOTAL_BITS-1:0] i_balance,
  input  logic                  i_trigger_return,
  input  logic                  i_activity,
  input  logic                  i_hopper_ready,
  output logic [NUM_COINS-1:0]  o_return_coin,
  output logic                  o_returning,
  output logic [31:0]           o_wait_time,
  output logic                  o_done,
  output logic [TOTAL_BITS-1:0] o_residue
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_WAIT   = 2'd1;
  localparam logic [1:0] S_RETURN = 2'd2;

  localparam logic [TOTAL_BITS-1:0] C_MIN    = TOTAL_BITS'(COIN_VAL0);
  localparam logic [31:0]           C_RELOAD = 32'(WAIT_CYCLES);

  function automatic logic [TOTAL_BITS-1:0] coin_val(input int k);
    case (k)
      0:       return TOTAL_BITS'(COIN_VAL0);
      1:       return TOTAL_BITS'(COIN_VAL1);
      default: return TOTAL_BITS'(COIN_VAL2);
    endcase
  endfunction

  logic [1:0]            r_state;
  logic [31:0]           r_timer;
  logic [TOTAL_BITS-1:0] r_remaining;
  logic                  r_done;
  logic [TOTAL_BITS-1:0] r_residue;

  logic [NUM_COINS-1:0]  w_sel;
  logic [TOTAL_BITS-1:0] w_val;
  logic [NUM_COINS-1:0]  w_strobe;
  logic [TOTAL_BITS-1:0] w_next_rem;

  // Denominations ascend with index, so the last fitting coin is the largest.
  always_comb begin
    w_sel = '0;
    w_val = '0;
    for (int k = 0; k < NUM_COINS; k++) begin
      if (r_remaining >= coin_val(k)) begin
        w_sel    = '0;
        w_sel[k] = 1'b1;
        w_val    = coin_val(k);
      end
    end
  end

  assign w_strobe   = (r_state == S_RETURN && i_hopper_ready) ? w_sel : '0;
  assign w_next_rem = r_remaining - ((|w_strobe) ? w_val : '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_timer     <= C_RELOAD;
      r_remaining <= '0;
      r_done      <= 1'b0;
      r_residue   <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_timer <= C_RELOAD;
          if (i_balance >= C_MIN) r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (i_trigger_return) begin
            r_state     <= S_RETURN;
            r_remaining <= i_balance;
          end else if (i_activity) begin
            r_timer <= C_RELOAD;
          end else if (r_timer == 32'd0) begin
            r_state     <= S_RETURN;
            r_remaining <= i_balance;
          end else if (i_balance < C_MIN) begin
            r_state <= S_IDLE;
            r_timer <= C_RELOAD;
          end else begin
            r_timer <= r_timer - 32'd1;
          end
        end
        S_RETURN: begin
          // Finish on the edge that takes the last coin so N coins cost N cycles.
          r_remaining <= w_next_rem;
          if (w_next_rem < C_MIN) begin
            r_state   <= S_IDLE;
            r_residue <= w_next_rem;
            r_done    <= 1'b1;
            r_timer   <= C_RELOAD;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_return_coin = w_strobe;
  assign o_returning   = (r_state == S_RETURN);
  assign o_wait_time   = r_timer;
  assign o_done        = r_done;
  assign o_residue     = r_residue;

endmodule
